// File: rtl/text_buffer.sv
// text_buffer: character-cell text buffer feeding the console glyph renderer.
//
// Write side: bytes arrive on a valid/ready handshake and are placed at a hardware cursor.
// LF, CR, BS and FF are control codes. Every other code is written at the cursor, which
// then advances; writing the last column wraps to the next line. The screen is a circular
// buffer of rows: scrolling advances top_row and blanks the new bottom physical row.
// Read side: the pixel position (cx, cy) selects a cell. character/attribute follow two
// cycles later, one cycle for the RAM register and one for the output register.
//
// Optional feature: define TEXT_BUFFER_CURSOR_EN to show a blinking cursor. The cell under
// the cursor has its attribute nibbles swapped while bit 5 of a frame counter is set.
//
// Ports:
//   clk_pixel            sole clock; both RAM ports run in this domain
//   reset                synchronous, active-high
//   in_valid / in_ready  byte handshake; in_ready is high only in the idle state
//   in_char, in_attr     character or control code, and attribute for printable codes
//   cx, cy               pixel column / row from the HDMI timing generator
//   character, attribute cell contents for (cx, cy) presented two cycles earlier
//   cursor_col           cursor column
//   cursor_row           cursor logical row
module text_buffer #(
    parameter int unsigned COLUMNS    = 80,
    parameter int unsigned ROWS       = 30,
    parameter logic [7:0]  BLANK_ATTR = 8'h0F
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic [7:0] in_attr,
    input  logic [9:0] cx,
    input  logic [9:0] cy,
    output logic [7:0] character,
    output logic [7:0] attribute,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row
);
    localparam int unsigned CELLS = COLUMNS * ROWS;
    localparam int unsigned AW = $clog2(CELLS);
    localparam logic [15:0] BLANK_WORD = {BLANK_ATTR, 8'h20};
    localparam logic [9:0] X_LIMIT = 10'(COLUMNS * 8);
    localparam logic [9:0] Y_LIMIT = 10'(ROWS * 16);
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);
    localparam logic [AW-1:0] LAST_COL_CELL = AW'(COLUMNS - 1);
    localparam logic [6:0] LAST_COL = 7'(COLUMNS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    typedef enum logic [1:0] {StClearAll, StIdle, StClearRow} state_e;

    // Logical row to physical row; both operands are below ROWS, so one subtract suffices.
    function automatic logic [4:0] phys_row(input logic [5:0] row, input logic [4:0] top);
        logic [6:0] sum;
        sum = {1'b0, row} + {2'b00, top};
        if (sum >= 7'(ROWS)) begin
            sum = sum - 7'(ROWS);
        end
        return sum[4:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
        return AW'(prow) * AW'(COLUMNS) + AW'(col);
    endfunction

    state_e        r_state;
    state_e        w_state_next;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] r_clr_base;
    logic [6:0]    r_col;
    logic [4:0]    r_row;
    logic [4:0]    r_top_row;
    logic [15:0]   r_mem [CELLS];
    logic [15:0]   r_ram_q;
    logic          r_rd_blank;
    logic [7:0]    r_char;
    logic [7:0]    r_attr;

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [15:0]   w_wdata;
    logic [AW-1:0] w_cur_addr;
    logic [AW-1:0] w_raddr;
    logic          w_rd_blank;
    logic [15:0]   w_ram_word;
    logic [6:0]    w_col_next;
    logic [4:0]    w_row_next;
    logic [4:0]    w_top_next;
    logic          w_lf;
    logic          w_scroll;
    logic          w_ff;

    assign w_cur_addr = cell_addr(phys_row({1'b0, r_row}, r_top_row), r_col);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state <= StClearAll;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StClearAll: begin
                if (r_clr_cnt == LAST_CELL) w_state_next = StIdle;
            end
            StIdle: begin
                if (w_ff) begin
                    w_state_next = StClearAll;
                end else if (w_scroll) begin
                    w_state_next = StClearRow;
                end
            end
            StClearRow: begin
                if (r_clr_cnt == LAST_COL_CELL) w_state_next = StIdle;
            end
            default: w_state_next = StClearAll;
        endcase
    end

    // ---------------- FSM: outputs, RAM write and cursor next values ----------------
    always_comb begin
        in_ready   = 1'b0;
        w_we       = 1'b0;
        w_waddr    = r_clr_cnt;
        w_wdata    = BLANK_WORD;
        w_col_next = r_col;
        w_row_next = r_row;
        w_top_next = r_top_row;
        w_lf       = 1'b0;
        w_scroll   = 1'b0;
        w_ff       = 1'b0;
        unique case (r_state)
            StClearAll: begin
                w_we = 1'b1;
                if (r_clr_cnt == LAST_CELL) begin
                    w_col_next = '0;
                    w_row_next = '0;
                    w_top_next = '0;
                end
            end
            StClearRow: begin
                w_we    = 1'b1;
                w_waddr = r_clr_base + r_clr_cnt;
            end
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (in_char)
                        8'h0A: begin
                            w_col_next = '0;
                            w_lf       = 1'b1;
                        end
                        8'h0D: w_col_next = '0;
                        8'h08: begin
                            if (r_col != '0) w_col_next = r_col - 7'd1;
                        end
                        8'h0C: w_ff = 1'b1;
                        default: begin
                            w_we    = 1'b1;
                            w_waddr = w_cur_addr;
                            w_wdata = {in_attr, in_char};
                            // Auto-wrap: the write still lands in the last column first.
                            if (r_col == LAST_COL) begin
                                w_col_next = '0;
                                w_lf       = 1'b1;
                            end else begin
                                w_col_next = r_col + 7'd1;
                            end
                        end
                    endcase
                end
            end
            default: ;
        endcase
        // Line feed on the bottom row scrolls: the row index stays and top_row advances.
        if (w_lf) begin
            if (r_row < LAST_ROW) begin
                w_row_next = r_row + 5'd1;
            end else begin
                w_scroll   = 1'b1;
                w_top_next = (r_top_row == LAST_ROW) ? '0 : r_top_row + 5'd1;
            end
        end
    end

    // ---------------- cursor, scroll and clear bookkeeping ----------------
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_clr_cnt  <= '0;
            r_clr_base <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_top_row  <= '0;
        end else begin
            r_col     <= w_col_next;
            r_row     <= w_row_next;
            r_top_row <= w_top_next;
            if (w_state_next == StIdle || w_state_next != r_state) begin
                r_clr_cnt <= '0;
            end else begin
                r_clr_cnt <= r_clr_cnt + AW'(1);
            end
            // The new bottom physical row is the one that was at the top before scrolling.
            if (w_scroll) r_clr_base <= cell_addr(r_top_row, 7'd0);
        end
    end

    assign cursor_col = r_col;
    assign cursor_row = r_row;

    // ---------------- dual-port RAM: read returns old data on a same-address write --------
    assign w_rd_blank = (cx >= X_LIMIT) || (cy >= Y_LIMIT);
    assign w_raddr    = w_rd_blank ? '0 : cell_addr(phys_row(cy[9:4], r_top_row), cx[9:3]);

    always_ff @(posedge clk_pixel) begin
        if (w_we && !reset) r_mem[w_waddr] <= w_wdata;
        r_ram_q <= r_mem[w_raddr];
    end

`ifdef TEXT_BUFFER_CURSOR_EN
    logic [5:0] r_blink;
    logic       r_at_cursor;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_blink     <= '0;
            r_at_cursor <= 1'b0;
        end else begin
            if (cx == '0 && cy == '0) r_blink <= r_blink + 6'd1;
            r_at_cursor <= !w_rd_blank && (w_raddr == w_cur_addr);
        end
    end

    always_comb begin
        w_ram_word = r_ram_q;
        if (r_at_cursor && r_blink[5]) begin
            w_ram_word = {r_ram_q[11:8], r_ram_q[15:12], r_ram_q[7:0]};
        end
    end
`else
    assign w_ram_word = r_ram_q;
`endif

    // ---------------- read pipeline: blank flag alongside RAM data, then output register ----
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_rd_blank <= 1'b1;
            r_char     <= 8'h20;
            r_attr     <= BLANK_ATTR;
        end else begin
            r_rd_blank <= w_rd_blank;
            if (r_rd_blank) begin
                {r_attr, r_char} <= BLANK_WORD;
            end else begin
                {r_attr, r_char} <= w_ram_word;
            end
        end
    end

    assign character = r_char;
    assign attribute = r_attr;

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer: cursor/handshake vectors from a table, a screen
// model with a queue of expected pixel lookups, and hand-written scroll / clear sequences.
module tb_text_buffer;
    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic [7:0] in_attr;
    logic [9:0] cx;
    logic [9:0] cy;
    logic [7:0] character;
    logic [7:0] attribute;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;

    always #5 clk_pixel = ~clk_pixel;

    text_buffer dut (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .in_attr   (in_attr),
        .cx        (cx),
        .cy        (cy),
        .character (character),
        .attribute (attribute),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row)
    );

    typedef struct {
        int         due;
        logic [7:0] c;
        logic [7:0] a;
        string      name;
    } exp_t;

    typedef struct {
        logic [7:0] ch;
        logic [7:0] at;
        int         col;
        int         row;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [15:0] mdl [ROWS][COLS];
    int          mcol;
    int          mrow;
    vec_t        tbl [10];

    // One clock; outputs are sampled 1 time unit after the edge, then due lookups compared.
    task automatic step();
        @(posedge clk_pixel);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (e.due != cyc || character !== e.c || attribute !== e.a) begin
                errors++;
                $display("FAIL %s: got char/attr %h/%h want %h/%h", e.name, character,
                         attribute, e.c, e.a);
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_at(input int x, input int y);
        if (x >= COLS * 8 || y >= ROWS * 16) return 16'h0F20;
        return mdl[y / 16][x / 8];
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) mdl[r][c] = 16'h0F20;
        mcol = 0;
        mrow = 0;
    endtask

    task automatic model_lf();
        if (mrow < ROWS - 1) begin
            mrow++;
        end else begin
            for (int r = 0; r < ROWS - 1; r++)
                for (int c = 0; c < COLS; c++) mdl[r][c] = mdl[r + 1][c];
            for (int c = 0; c < COLS; c++) mdl[ROWS - 1][c] = 16'h0F20;
        end
    endtask

    task automatic model_byte(input logic [7:0] ch, input logic [7:0] at);
        case (ch)
            8'h0A: begin mcol = 0; model_lf(); end
            8'h0D: mcol = 0;
            8'h08: if (mcol > 0) mcol--;
            8'h0C: model_clear();
            default: begin
                mdl[mrow][mcol] = {at, ch};
                if (mcol == COLS - 1) begin
                    mcol = 0;
                    model_lf();
                end else begin
                    mcol++;
                end
            end
        endcase
    endtask

    // Present a byte until accepted (bounded), then update the model.
    task automatic send(input logic [7:0] ch, input logic [7:0] at);
        int n = 0;
        in_valid = 1'b1;
        in_char  = ch;
        in_attr  = at;
        while (!in_ready && n < 5000) begin
            step();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready still %0d after %0d cycles want 1", in_ready, n);
        end
        step();
        in_valid = 1'b0;
        model_byte(ch, at);
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int n = 0;
        while (!in_ready && n < 5000) begin
            step();
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    task automatic lookup(input int x, input int y, input string name);
        exp_t        e;
        logic [15:0] w;
        w      = model_at(x, y);
        cx     = x[9:0];
        cy     = y[9:0];
        e.due  = cyc + 2;
        e.c    = w[7:0];
        e.a    = w[15:8];
        e.name = name;
        sb.push_back(e);
        step();
    endtask

    task automatic flush();
        cx = 10'd1023;
        cy = 10'd1023;
        step();
        step();
        step();
    endtask

    task automatic sweep(input string name);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int x = c * 8 + int'($urandom_range(0, 7));
                int y = r * 16 + int'($urandom_range(0, 15));
                lookup(x, y, name);
            end
        end
        flush();
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        check({name, "_col"}, cursor_col, col);
        check({name, "_row"}, cursor_row, row);
    endtask

    initial begin
        tbl[0] = '{8'h42, 8'h2F, 2, 0};
        tbl[1] = '{8'h0D, 8'h00, 0, 0};
        tbl[2] = '{8'h08, 8'h00, 0, 0};
        tbl[3] = '{8'h43, 8'h07, 1, 0};
        tbl[4] = '{8'h0A, 8'h00, 0, 1};
        tbl[5] = '{8'h44, 8'h70, 1, 1};
        tbl[6] = '{8'h08, 8'h00, 0, 1};
        tbl[7] = '{8'h45, 8'h4E, 1, 1};
        tbl[8] = '{8'h0D, 8'h00, 0, 1};
        tbl[9] = '{8'h08, 8'h00, 0, 1};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_char  = 8'h00;
        in_attr  = 8'h00;
        cx       = 10'd1023;
        cy       = 10'd1023;
        model_clear();
        repeat (3) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_char", character, 8'h20);
        check("rst_attr", attribute, 8'h0F);
        check_cursor("rst", 0, 0);

        reset = 1'b0;
        wait_ready("init_clear_cycles", 2400);
        sweep("blank_init");

        // First character, then every pixel of its cell plus the next cell.
        send(8'h41, 8'h1E);
        check_cursor("first", 1, 0);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++) lookup(x, y, "cell00_pixels");
        lookup(8, 0, "cell10_blank");
        flush();

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].ch, tbl[i].at);
            check($sformatf("tbl%0d_col", i), cursor_col, tbl[i].col);
            check($sformatf("tbl%0d_row", i), cursor_row, tbl[i].row);
        end
        sweep("after_table");

        send(8'h0C, 8'h00);
        wait_ready("ff1_cycles", 2400);
        check_cursor("ff1", 0, 0);

        for (int i = 0; i < COLS; i++) send(8'h61 + 8'(i % 26), 8'(i));
        check_cursor("wrap80", 0, 1);
        send(8'h5A, 8'h5A);
        check_cursor("byte81", 1, 1);
        lookup(0, 16, "byte81_cell");
        flush();
        send(8'h0D, 8'h00);
        check_cursor("cr", 0, 1);
        send(8'h08, 8'h00);
        check_cursor("bs_col0", 0, 1);

        for (int i = 0; i < ROWS - 2; i++) send(8'h0A, 8'h00);
        check_cursor("lf_bottom", 0, 29);
        check("lf_bottom_ready", in_ready, 1);
        send(8'h51, 8'h3C);
        send(8'h0A, 8'h00);
        wait_ready("scroll_lf_cycles", 80);
        check_cursor("scroll_lf", 0, 29);
        sweep("after_scroll_lf");

        for (int i = 0; i < COLS - 1; i++) send(8'h30 + 8'(i % 10), 8'h21);
        check("wrap_row_ready", in_ready, 1);
        send(8'h7E, 8'h12);
        wait_ready("scroll_wrap_cycles", 80);
        check_cursor("scroll_wrap", 0, 29);
        sweep("after_scroll_wrap");

        lookup(700, 0, "oor_cx700");
        lookup(0, 500, "oor_cy500");
        lookup(640, 0, "oor_cx640");
        lookup(639, 0, "edge_cx639");
        lookup(0, 480, "oor_cy480");
        lookup(0, 479, "edge_cy479");
        lookup(639, 479, "edge_corner");
        flush();

        // Reset in the middle of a scroll clear restarts the full clear.
        send(8'h0A, 8'h00);
        repeat (10) step();
        reset = 1'b1;
        step();
        check("midrst_in_ready", in_ready, 0);
        check("midrst_char", character, 8'h20);
        reset = 1'b0;
        model_clear();
        wait_ready("midrst_clear_cycles", 2400);
        check_cursor("midrst", 0, 0);
        sweep("after_midrst");

        send(8'h68, 8'h1E);
        send(8'h0A, 8'h00);
        send(8'h69, 8'h1E);
        send(8'h0C, 8'h00);
        wait_ready("ff2_cycles", 2400);
        check_cursor("ff2", 0, 0);
        sweep("after_ff2");

`ifdef TEXT_BUFFER_CURSOR_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_clear();
        wait_ready("blink_clear_cycles", 2400);
        send(8'h0A, 8'h00);
        send(8'h0A, 8'h00);
        send(8'h61, 8'h07);
        send(8'h62, 8'h07);
        send(8'h63, 8'h07);
        send(8'h58, 8'h1E);
        send(8'h08, 8'h00);
        check_cursor("blink_pos", 3, 2);
        lookup(25, 35, "blink_frame0_cursor");
        lookup(8, 32, "blink_frame0_other");
        flush();
        cx = 10'd0;
        cy = 10'd0;
        repeat (32) step();
        mdl[2][3] = {8'hE1, 8'h58};
        lookup(25, 35, "blink_frame32_cursor");
        lookup(8, 32, "blink_frame32_other");
        flush();
`endif

        flush();
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
